// File: rtl/dut_bist_sequencer_pkg.sv
// Shared types, constants and pure step functions for the BIST sequencer.
package dut_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
   localparam logic [15:0] MISR_POLY     = 16'h1021;
   localparam logic [7:0]  LFSR_ZERO_SUB = 8'h01;

   // Fibonacci step: feedback is the XOR of the tapped bits q7^q5^q4^q3.
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

   function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [7:0] d);
      return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {8'h00, d};
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dut_bist_sequencer_if.sv
// Control, stimulus and result signals between the bench/top level and the sequencer.
interface dut_bist_sequencer_if;
   logic        start;
   logic [7:0]  seed;
   logic        dut_clear;
   logic [7:0]  dut_input;
   logic [7:0]  dut_output;
   logic        busy;
   logic        done;
   logic [15:0] signature;

   modport master (
      output start, seed, dut_output,
      input  dut_clear, dut_input, busy, done, signature
   );

   modport slave (
      input  start, seed, dut_output,
      output dut_clear, dut_input, busy, done, signature
   );
endinterface

// File: rtl/dut_bist_sequencer_misr16.sv
// 16-bit Galois MISR compressing one 8-bit DUT sample per enabled cycle.
module misr16
   import dut_bist_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [15:0] sig
);

   logic [15:0] sig_q;

   // Signature register; clear wins over capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sig_q <= 16'h0000;
      end else if (clr) begin
         sig_q <= 16'h0000;
      end else if (en) begin
         sig_q <= misr_next(sig_q, din);
      end else begin
         sig_q <= sig_q;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/dut_bist_sequencer.sv
// BIST sequencer: clears the DUT, drives LFSR stimulus and compresses its output into a MISR.
module dut_bist_sequencer
   import dut_bist_pkg::*;
#(
   parameter int unsigned NUM_VECTORS  = 256,
   parameter int unsigned CLEAR_CYCLES = 2,
   parameter int unsigned DUT_LATENCY  = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   dut_bist_sequencer_if.slave bus
);

   localparam int unsigned CNT_MAX = max3(NUM_VECTORS, CLEAR_CYCLES, DUT_LATENCY);
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_CYCLES - 1);
   localparam logic [CW-1:0] RUN_LAST   = CW'(NUM_VECTORS - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DUT_LATENCY - 1);
   localparam logic [CW:0]   LAT_W      = (CW+1)'(DUT_LATENCY);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic          dut_clear_q, dut_clear_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          misr_clr_s;
   logic          misr_en_s;
   logic          run_capture_s;
   logic [15:0]   signature_s;

   // RUN cycle k captures once k >= DUT_LATENCY, i.e. k+1 > DUT_LATENCY.
   assign run_capture_s = (({1'b0, cnt_q} + (CW+1)'(1)) > LAT_W);

   // Next-state, counter, LFSR and registered-output decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lfsr_d     = lfsr_q;
      misr_clr_s = 1'b0;
      misr_en_s  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               lfsr_d     = (bus.seed == 8'h00) ? LFSR_ZERO_SUB : bus.seed;
               cnt_d      = '0;
               misr_clr_s = 1'b1;
               state_d    = ST_CLEAR;
            end else begin
               state_d = state_q;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == CLR_LAST) begin
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RUN: begin
            lfsr_d    = lfsr_next(lfsr_q);
            misr_en_s = run_capture_s;
            if (cnt_q == RUN_LAST) begin
               cnt_d   = '0;
               state_d = (DUT_LATENCY == 0) ? ST_DONE : ST_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DRAIN: begin
            misr_en_s = 1'b1;
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      dut_clear_d = (state_d == ST_CLEAR);
      busy_d      = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d      = (state_d == ST_DONE);
   end

   // State, counter, LFSR and output flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         lfsr_q      <= 8'h01;
         dut_clear_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         dut_clear_q <= dut_clear_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   misr16 u_misr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (misr_clr_s),
      .en      (misr_en_s),
      .din     (bus.dut_output),
      .sig     (signature_s)
   );

   assign bus.dut_clear = dut_clear_q;
   assign bus.dut_input = lfsr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.signature = signature_s;

endmodule

// File: tb/tb_dut_bist_sequencer.sv
// Scoreboard bench: a long-run instance (256 vectors, combinational DUT) and a short
// instance (2 vectors, one-cycle registered DUT), checked against a sequence-level model.
module tb_dut_bist_sequencer;

   localparam int A_NV = 256;
   localparam int A_CC = 2;
   localparam int A_L  = 0;
   localparam int B_NV = 2;
   localparam int B_CC = 2;
   localparam int B_L  = 1;

   typedef struct packed {
      logic [15:0] sig;
      logic [31:0] done_cyc;
      logic [31:0] first4;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   checks;
   int   failures;

   int         mode_a, mode_b;
   logic [7:0] key_a, key_b;
   logic [7:0] b_reg;
   logic [7:0] run_seed;

   exp_t q_a[$];
   exp_t q_b[$];

   dut_bist_sequencer_if a ();
   dut_bist_sequencer_if b ();

   dut_bist_sequencer #(.NUM_VECTORS(A_NV), .CLEAR_CYCLES(A_CC), .DUT_LATENCY(A_L)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(a));

   dut_bist_sequencer #(.NUM_VECTORS(B_NV), .CLEAR_CYCLES(B_CC), .DUT_LATENCY(B_L)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural DUT variants: 0 pass-through, 1 tied zero, 2 tied one, 3 xor with key.
   function automatic logic [7:0] dut_fn(input logic [7:0] x, input int mode, input logic [7:0] key);
      case (mode)
         0:       return x;
         1:       return 8'h00;
         2:       return 8'h01;
         default: return x ^ key;
      endcase
   endfunction

   function automatic logic [7:0] tb_lfsr(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   // Signature over the whole stimulus list: every vector's response is captured once, in order.
   function automatic logic [15:0] ref_sig(input logic [7:0] seed, input int mode,
                                           input logic [7:0] key, input int nv);
      logic [7:0]  s;
      logic [7:0]  d;
      logic [15:0] sig;
      s   = (seed == 8'h00) ? 8'h01 : seed;
      sig = 16'h0000;
      for (int k = 0; k < nv; k++) begin
         d   = dut_fn(s, mode, key);
         sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {8'h00, d};
         s   = tb_lfsr(s);
      end
      return sig;
   endfunction

   function automatic logic [31:0] ref_first4(input logic [7:0] seed);
      logic [7:0]  s;
      logic [31:0] r;
      s = (seed == 8'h00) ? 8'h01 : seed;
      r = 32'h0;
      for (int k = 0; k < 4; k++) begin
         r = {r[23:0], s};
         s = tb_lfsr(s);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   assign a.dut_output = dut_fn(a.dut_input, mode_a, key_a);

   // One-cycle-latency DUT model for instance B, cleared by dut_clear.
   always @(posedge clk) begin
      if (b.dut_clear) b_reg <= 8'h00;
      else             b_reg <= b.dut_input ^ key_b;
   end
   assign b.dut_output = (mode_b == 2) ? 8'h01 : b_reg;

   task automatic launch_a(input logic [7:0] seed);
      exp_t e;
      @(negedge clk);
      a.start    = 1'b1;
      a.seed     = seed;
      e.sig      = ref_sig(seed, mode_a, key_a, A_NV);
      e.done_cyc = 32'(cyc + 1 + A_CC + A_NV + A_L);
      e.first4   = ref_first4(seed);
      q_a.push_back(e);
      @(negedge clk);
      a.start = 1'b0;
   endtask

   task automatic launch_b(input logic [7:0] seed);
      exp_t e;
      @(negedge clk);
      b.start    = 1'b1;
      b.seed     = seed;
      e.sig      = ref_sig(seed, mode_b, key_b, B_NV);
      e.done_cyc = 32'(cyc + 1 + B_CC + B_NV + B_L);
      e.first4   = 32'h0;
      q_b.push_back(e);
      @(negedge clk);
      b.start = 1'b0;
   endtask

   task automatic wait_done_a();
      int n;
      n = 0;
      while (!a.done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("a_done_timeout", 32'(a.done), 32'd1);
   endtask

   task automatic wait_done_b();
      int n;
      n = 0;
      while (!b.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("b_done_timeout", 32'(b.done), 32'd1);
   endtask

   // Monitor A: on each done rise pop the oldest expectation and compare the run.
   initial begin
      int          clr_cnt;
      int          run_idx;
      logic [31:0] obs_first;
      logic        done_prev;
      exp_t        e;
      clr_cnt = 0; run_idx = 0; obs_first = 32'h0; done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            clr_cnt = 0; run_idx = 0; obs_first = 32'h0; done_prev = 1'b0;
         end else begin
            if (a.busy && a.dut_clear) clr_cnt++;
            if (a.busy && !a.dut_clear && run_idx < 4) begin
               obs_first = {obs_first[23:0], a.dut_input};
               run_idx++;
            end
            if (a.done && !done_prev) begin
               if (q_a.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL a_unexpected_done actual=done required=no_run_pending");
               end else begin
                  e = q_a.pop_front();
                  check("a_signature", 32'(a.signature), 32'(e.sig));
                  check("a_done_cycle", 32'(cyc), e.done_cyc);
                  check("a_clear_cycles", 32'(clr_cnt), 32'(A_CC));
                  check("a_first_inputs", obs_first, e.first4);
                  check("a_busy_at_done", 32'(a.busy), 32'd0);
               end
               clr_cnt = 0; run_idx = 0; obs_first = 32'h0;
            end
            done_prev = a.done;
         end
      end
   end

   // Monitor B: signature and completion time per run.
   initial begin
      logic done_prev;
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            done_prev = 1'b0;
         end else begin
            if (b.done && !done_prev) begin
               if (q_b.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL b_unexpected_done actual=done required=no_run_pending");
               end else begin
                  e = q_b.pop_front();
                  check("b_signature", 32'(b.signature), 32'(e.sig));
                  check("b_done_cycle", 32'(cyc), e.done_cyc);
                  check("b_busy_at_done", 32'(b.busy), 32'd0);
               end
            end
            done_prev = b.done;
         end
      end
   end

   initial begin
      checks = 0; failures = 0;
      reset_n = 1'b0;
      a.start = 1'b0; a.seed = 8'h00; b.start = 1'b0; b.seed = 8'h00;
      mode_a = 0; key_a = 8'h00; mode_b = 2; key_b = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_dut_clear", 32'(a.dut_clear), 32'd0);
      check("rst_busy", 32'(a.busy), 32'd0);
      check("rst_done", 32'(a.done), 32'd0);
      check("rst_signature", 32'(a.signature), 32'd0);
      check("rst_dut_input", 32'(a.dut_input), 32'h01);
      check("rst_b_busy", 32'(b.busy), 32'd0);
      reset_n = 1'b1;

      mode_a = 0;
      launch_a(8'hAA);
      wait_done_a();

      mode_a = 3; key_a = 8'($urandom);
      launch_a(8'($urandom_range(1, 255)));
      wait_done_a();

      mode_a = 0;
      launch_a(8'($urandom));
      check("a_sig_cleared_on_restart", 32'(a.signature), 32'd0);
      wait_done_a();

      mode_a = 1;
      launch_a(8'($urandom));
      wait_done_a();

      mode_a = 3; key_a = 8'($urandom);
      launch_a(8'($urandom));
      repeat (40) @(negedge clk);
      a.start = 1'b1; a.seed = 8'($urandom);
      @(negedge clk);
      a.start = 1'b0;
      wait_done_a();

      mode_a = 0;
      launch_a(8'h00);
      wait_done_a();

      mode_a = 3; key_a = 8'($urandom);
      run_seed = 8'($urandom);
      launch_a(run_seed);
      repeat (100) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrun_rst_dut_clear", 32'(a.dut_clear), 32'd0);
      check("midrun_rst_busy", 32'(a.busy), 32'd0);
      check("midrun_rst_done", 32'(a.done), 32'd0);
      check("midrun_rst_signature", 32'(a.signature), 32'd0);
      check("midrun_rst_dut_input", 32'(a.dut_input), 32'h01);
      q_a.delete();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      launch_a(run_seed);
      wait_done_a();

      mode_b = 2;
      launch_b(8'($urandom));
      wait_done_b();
      check("b_tied_one_signature", 32'(b.signature), 32'h0003);
      mode_b = 3;
      for (int i = 0; i < 4; i++) begin
         key_b = 8'($urandom);
         launch_b(8'($urandom));
         wait_done_b();
      end

      repeat (2) @(negedge clk);
      check("a_queue_drained", 32'(q_a.size()), 32'd0);
      check("b_queue_drained", 32'(q_b.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
